sat_accum_adder: RTL and testbench

SAT_ACCUM_ADDER -- requirements
Module: sat_accum_adder

---
 rtl/sat_accum_adder.sv | 107 ++++++++++
 tb/tb_sat_accum_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sat_accum_adder.sv
// Unsigned add/sub/accumulate unit with optional saturation, one-deep output
// register and valid/ready handshake on both sides; latency is one cycle.
module sat_accum_adder #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds op/a/b while in_ready is low, and the result
  // stays stable while out_valid is high and out_ready is low.

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH:0]   ext;
  logic             range_err;
  logic [WIDTH-1:0] res_val;

  assign in_ready = ena & ~rst & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign deliver  = ena & out_valid_q & out_ready;

  // Bit WIDTH of the extended result is the carry for add-type ops and the
  // borrow for SUB, so one bit flags out-of-range for every arithmetic op.
  always_comb begin
    ext       = '0;
    range_err = 1'b0;
    res_val   = '0;
    case (op)
      OP_ADD: ext = {1'b0, a} + {1'b0, b};
      OP_SUB: ext = {1'b0, a} - {1'b0, b};
      OP_ACC: ext = {1'b0, acc_q} + {1'b0, a};
      default: ext = '0;
    endcase
    range_err = (op != OP_CLR) & ext[WIDTH];
    if (range_err && SATURATE)
      res_val = (op == OP_SUB) ? '0 : '1;
    else
      res_val = ext[WIDTH-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = res_val;
      ovf_d       = range_err;
      sticky_d    = (op == OP_CLR) ? 1'b0 : (sticky_q | range_err);
      if (op == OP_ACC || op == OP_CLR)
        acc_d = res_val;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign acc        = acc_q;

endmodule

// File: tb/tb_sat_accum_adder.sv
// Directed bench for sat_accum_adder: a saturating and a wrapping instance
// share stimulus; expected values are hand-computed constants.
module tb_sat_accum_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_ready = 1'b0;

  logic         s_in_ready, s_out_valid, s_ovf, s_sticky;
  logic [W-1:0] s_result, s_acc;
  logic         w_in_ready, w_out_valid, w_ovf, w_sticky;
  logic [W-1:0] w_result, w_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_accum_adder #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .ovf(s_ovf), .ovf_sticky(s_sticky), .acc(s_acc)
  );

  sat_accum_adder #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
    .result(w_result), .ovf(w_ovf), .ovf_sticky(w_sticky), .acc(w_acc)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    in_valid = 1'b1;
    cycle();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", s_out_valid); end
    checks++; if (s_result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", s_result); end
    checks++; if (s_ovf !== 1'b0 || s_sticky !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", s_ovf, s_sticky); end
    checks++; if (s_acc !== 8'd0) begin errors++; $display("FAIL reset_acc got %0d exp 0", s_acc); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", s_in_ready); end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_add();
    drive(2'b00, 8'd200, 8'd100);
    #1;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", s_in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (s_result !== 8'd255 || s_ovf !== 1'b1 || s_sticky !== 1'b1) begin errors++; $display("FAIL add_sat got r=%0d o=%b s=%b exp r=255 o=1 s=1", s_result, s_ovf, s_sticky); end
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", s_out_valid); end
    checks++; if (w_result !== 8'd44 || w_ovf !== 1'b1) begin errors++; $display("FAIL add_wrap got r=%0d o=%b exp r=44 o=1", w_result, w_ovf); end
    checks++; if (s_acc !== 8'd0) begin errors++; $display("FAIL add_acc_untouched got %0d exp 0", s_acc); end
    drive(2'b00, 8'd10, 8'd20);
    cycle();
    in_valid = 1'b0;
    checks++; if (s_result !== 8'd30 || s_ovf !== 1'b0 || s_sticky !== 1'b1) begin errors++; $display("FAIL add_plain got r=%0d o=%b s=%b exp r=30 o=0 s=1", s_result, s_ovf, s_sticky); end
    cycle();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", s_out_valid); end
  endtask

  task automatic test_sub();
    drive(2'b01, 8'd5, 8'd9);
    cycle();
    checks++; if (s_result !== 8'd0 || s_ovf !== 1'b1) begin errors++; $display("FAIL sub_sat got r=%0d o=%b exp r=0 o=1", s_result, s_ovf); end
    checks++; if (w_result !== 8'd252 || w_ovf !== 1'b1) begin errors++; $display("FAIL sub_wrap got r=%0d o=%b exp r=252 o=1", w_result, w_ovf); end
    drive(2'b01, 8'd9, 8'd5);
    cycle();
    in_valid = 1'b0;
    checks++; if (s_result !== 8'd4 || s_ovf !== 1'b0 || w_result !== 8'd4) begin errors++; $display("FAIL sub_plain got r=%0d o=%b wr=%0d exp 4 0 4", s_result, s_ovf, w_result); end
    drive(2'b01, 8'd7, 8'd7);
    cycle();
    in_valid = 1'b0;
    checks++; if (s_result !== 8'd0 || s_ovf !== 1'b0) begin errors++; $display("FAIL sub_equal got r=%0d o=%b exp r=0 o=0", s_result, s_ovf); end
    cycle();
  endtask

  task automatic test_acc_clr();
    drive(2'b11, 8'd0, 8'd0);
    cycle();
    checks++; if (s_acc !== 8'd0 || s_sticky !== 1'b0 || s_out_valid !== 1'b1 || s_result !== 8'd0) begin errors++; $display("FAIL clr_first got acc=%0d s=%b v=%b r=%0d exp 0 0 1 0", s_acc, s_sticky, s_out_valid, s_result); end
    drive(2'b10, 8'd100, 8'd77);
    cycle();
    checks++; if (s_result !== 8'd100 || s_acc !== 8'd100 || s_ovf !== 1'b0) begin errors++; $display("FAIL acc_1 got r=%0d acc=%0d o=%b exp 100 100 0", s_result, s_acc, s_ovf); end
    cycle();
    checks++; if (s_result !== 8'd200 || s_acc !== 8'd200 || s_ovf !== 1'b0) begin errors++; $display("FAIL acc_2 got r=%0d acc=%0d o=%b exp 200 200 0", s_result, s_acc, s_ovf); end
    cycle();
    checks++; if (s_result !== 8'd255 || s_acc !== 8'd255 || s_ovf !== 1'b1 || s_sticky !== 1'b1) begin errors++; $display("FAIL acc_3 got r=%0d acc=%0d o=%b s=%b exp 255 255 1 1", s_result, s_acc, s_ovf, s_sticky); end
    checks++; if (w_result !== 8'd44 || w_acc !== 8'd44 || w_ovf !== 1'b1) begin errors++; $display("FAIL acc_wrap got r=%0d acc=%0d o=%b exp 44 44 1", w_result, w_acc, w_ovf); end
    drive(2'b11, 8'd0, 8'd0);
    cycle();
    in_valid = 1'b0;
    checks++; if (s_acc !== 8'd0 || s_sticky !== 1'b0 || s_ovf !== 1'b0 || s_out_valid !== 1'b1) begin errors++; $display("FAIL clr_after got acc=%0d s=%b o=%b v=%b exp 0 0 0 1", s_acc, s_sticky, s_ovf, s_out_valid); end
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(2'b00, 8'd1, 8'd2);
    cycle();
    drive(2'b00, 8'd4, 8'd5);
    #1;
    checks++; if (s_in_ready !== 1'b0 || s_result !== 8'd3 || s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall got rdy=%b r=%0d v=%b exp 0 3 1", s_in_ready, s_result, s_out_valid); end
    cycle();
    checks++; if (s_result !== 8'd3 || s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got r=%0d v=%b exp 3 1", s_result, s_out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", s_in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (s_result !== 8'd9 || s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_swap got r=%0d v=%b exp 9 1", s_result, s_out_valid); end
    cycle();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", s_out_valid); end
  endtask

  task automatic test_rst_priority();
    drive(2'b10, 8'd50, 8'd0);
    cycle();
    checks++; if (s_acc !== 8'd50) begin errors++; $display("FAIL rstp_setup got %0d exp 50", s_acc); end
    drive(2'b10, 8'd20, 8'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++; if (s_acc !== 8'd0 || s_out_valid !== 1'b0 || s_result !== 8'd0) begin errors++; $display("FAIL rstp_result got acc=%0d v=%b r=%0d exp 0 0 0", s_acc, s_out_valid, s_result); end
  endtask

  task automatic test_ena();
    out_ready = 1'b0;
    drive(2'b10, 8'd33, 8'd0);
    cycle();
    drive(2'b10, 8'd1, 8'd0);
    ena = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL ena_ready cyc %0d got %b exp 0", i, s_in_ready); end
      cycle();
      checks++; if (s_acc !== 8'd33 || s_result !== 8'd33 || s_out_valid !== 1'b1) begin errors++; $display("FAIL ena_frozen cyc %0d got acc=%0d r=%0d v=%b exp 33 33 1", i, s_acc, s_result, s_out_valid); end
    end
    ena = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL ena_resume_ready got %b exp 1", s_in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (s_acc !== 8'd34 || s_result !== 8'd34 || s_out_valid !== 1'b1) begin errors++; $display("FAIL ena_resume got acc=%0d r=%0d v=%b exp 34 34 1", s_acc, s_result, s_out_valid); end
    cycle();
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_sub();
    test_acc_clr();
    test_back_to_back();
    test_rst_priority();
    test_ena();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
